// File: rtl/imm_gen_pkg.sv
// Shared types and constants for the pipelined RISC-V immediate generator.
// Format codes, major-opcode values of inst[6:2], and the buffered entry layout.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'd0,
        FMT_S = 3'd1,
        FMT_B = 3'd2,
        FMT_U = 3'd3,
        FMT_J = 3'd4,
        FMT_Z = 3'd5,
        FMT_R = 3'd6
    } imm_fmt_e;

    localparam logic [4:0] OPC_LOAD      = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC     = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPC_STORE     = 5'b01000;
    localparam logic [4:0] OPC_OP        = 5'b01100;
    localparam logic [4:0] OPC_LUI       = 5'b01101;
    localparam logic [4:0] OPC_OP_32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH    = 5'b11000;
    localparam logic [4:0] OPC_JALR      = 5'b11001;
    localparam logic [4:0] OPC_JAL       = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

    localparam int XLEN_MAX  = 64;
    localparam int TAG_W_MAX = 64;

    // Entry layout at the widest configuration; the pipe keeps a width-exact copy.
    typedef struct packed {
        logic [XLEN_MAX-1:0]  imm;
        imm_fmt_e             fmt;
        logic                 illegal;
        logic [TAG_W_MAX-1:0] tag;
    } imm_entry_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational immediate decoder: classifies the format of a 32-bit instruction
// and builds its sign/zero-extended immediate at XLEN bits.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o
);

    localparam bit RV64 = (XLEN == 64);

    // Every format fits a signed 32-bit value, so build that first and widen once.
    logic [31:0] imm32;

    always_comb begin
        imm32     = '0;
        fmt_o     = FMT_R;
        illegal_o = 1'b0;
        if (inst_i[1:0] != 2'b11) begin
            illegal_o = 1'b1;
        end else begin
            case (inst_i[6:2])
                OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR: begin
                    fmt_o = FMT_I;
                    imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                end
                OPC_OP_IMM_32: begin
                    if (RV64) begin
                        fmt_o = FMT_I;
                        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                    end else begin
                        illegal_o = 1'b1;
                    end
                end
                OPC_STORE: begin
                    fmt_o = FMT_S;
                    imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
                end
                OPC_BRANCH: begin
                    fmt_o = FMT_B;
                    imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                             inst_i[30:25], inst_i[11:8], 1'b0};
                end
                OPC_AUIPC, OPC_LUI: begin
                    fmt_o = FMT_U;
                    imm32 = {inst_i[31:12], 12'b0};
                end
                OPC_JAL: begin
                    fmt_o = FMT_J;
                    imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                             inst_i[20], inst_i[30:21], 1'b0};
                end
                OPC_SYSTEM: begin
                    // CSR immediate forms carry a 5-bit unsigned uimm in the rs1 field.
                    if (inst_i[14]) begin
                        fmt_o = FMT_Z;
                        imm32 = {27'b0, inst_i[19:15]};
                    end else begin
                        fmt_o = FMT_I;
                        imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
                    end
                end
                OPC_OP: begin
                    fmt_o = FMT_R;
                end
                OPC_OP_32: begin
                    if (!RV64) begin
                        illegal_o = 1'b1;
                    end
                end
                default: begin
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational decode feeding a 2-entry
// valid/ready skid buffer with synchronous flush and reset.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        imm_fmt_e         fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .inst_i    (in_inst),
        .imm_o     (dec_imm),
        .fmt_o     (dec_fmt),
        .illegal_o (dec_illegal)
    );

    entry_t     mem_q [2];
    entry_t     new_entry;
    entry_t     head_entry;
    logic       head_q, head_d;
    logic [1:0] count_q, count_d;
    logic       push, pop, tail;

    assign new_entry = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: in_tag};

    // in_ready looks only at registered occupancy, never at out_ready.
    assign in_ready  = (count_q != 2'd2) && !rst;
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;
    assign tail      = head_q ^ count_q[0];

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        if (flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
        end else begin
            case ({push, pop})
                2'b10: count_d = count_q + 2'd1;
                2'b01: begin
                    count_d = count_q - 2'd1;
                    head_d  = ~head_q;
                end
                2'b11: head_d = ~head_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (rst) begin
                mem_q[gi] <= '0;
            end else if (push && (tail == 1'(gi))) begin
                mem_q[gi] <= new_entry;
            end
        end
    end

    // Empty buffer presents all-zero fields so reset and flush look identical downstream.
    assign head_entry  = out_valid ? mem_q[head_q] : '0;
    assign out_imm     = head_entry.imm;
    assign out_fmt     = head_entry.fmt;
    assign out_illegal = head_entry.illegal;
    assign out_tag     = head_entry.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32 and RV64 instances on shared stimulus, checked
// by a scoreboard fed from an arithmetic reference model of the immediate rules.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_tag = '0;
    logic        out_ready = 1'b0;

    logic        rdy32, rdy64, ov32, ov64, ill32, ill64;
    logic [31:0] imm32, tag32, tag64;
    logic [63:0] imm64;
    logic [2:0]  fmt32, fmt64;

    int checks = 0;
    int failures = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
        .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
        .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        int          fmt;
        bit          ill;
        logic [31:0] tag;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] sext(input logic [63:0] v, input int n);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (64'd1 << n) - 64'd1;
        r = v & mask;
        if (r[n-1]) r = r | ~mask;
        return r;
    endfunction

    // Reference: immediates assembled from instruction fields by shift-and-mask arithmetic.
    function automatic exp_t ref_model(input logic [31:0] inst, input int xlen, input logic [31:0] tag);
        exp_t        e;
        logic [63:0] w;
        int          opc;
        w     = 64'(inst);
        opc   = int'(inst[6:2]);
        e.imm = '0;
        e.fmt = int'(FMT_R);
        e.ill = 1'b0;
        e.tag = tag;
        if (inst[1:0] != 2'b11) begin
            e.ill = 1'b1;
        end else if (opc == 0 || opc == 3 || opc == 4 || opc == 25 ||
                     (opc == 6 && xlen == 64) || (opc == 28 && !inst[14])) begin
            e.fmt = int'(FMT_I);
            e.imm = sext(w >> 20, 12);
        end else if (opc == 8) begin
            e.fmt = int'(FMT_S);
            e.imm = sext(((w >> 25) << 5) | ((w >> 7) & 64'd31), 12);
        end else if (opc == 24) begin
            e.fmt = int'(FMT_B);
            e.imm = sext((((w >> 31) & 64'd1) << 12) | (((w >> 7) & 64'd1) << 11) |
                         (((w >> 25) & 64'd63) << 5) | (((w >> 8) & 64'd15) << 1), 13);
        end else if (opc == 5 || opc == 13) begin
            e.fmt = int'(FMT_U);
            e.imm = sext(w & 64'hFFFF_F000, 32);
        end else if (opc == 27) begin
            e.fmt = int'(FMT_J);
            e.imm = sext((((w >> 31) & 64'd1) << 20) | (((w >> 12) & 64'd255) << 12) |
                         (((w >> 20) & 64'd1) << 11) | (((w >> 21) & 64'd1023) << 1), 21);
        end else if (opc == 28) begin
            e.fmt = int'(FMT_Z);
            e.imm = (w >> 15) & 64'd31;
        end else if (opc == 12 || (opc == 14 && xlen == 64)) begin
            e.fmt = int'(FMT_R);
        end else begin
            e.ill = 1'b1;
        end
        if (xlen == 32) e.imm = e.imm & 64'hFFFF_FFFF;
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel != 15) begin
            r[1:0] = 2'b11;
            case (sel)
                0: r[6:2] = 5'b00000;  1: r[6:2] = 5'b00011;  2: r[6:2] = 5'b00100;
                3: r[6:2] = 5'b00101;  4: r[6:2] = 5'b00110;  5: r[6:2] = 5'b01000;
                6: r[6:2] = 5'b01100;  7: r[6:2] = 5'b01101;  8: r[6:2] = 5'b01110;
                9: r[6:2] = 5'b11000; 10: r[6:2] = 5'b11001; 11: r[6:2] = 5'b11011;
                12: r[6:2] = 5'b11100;
                default: ;
            endcase
        end
        return r;
    endfunction

    // Scoreboard input side: record every accepted instruction.
    always @(posedge clk) begin
        if (rst || flush) begin
            q32.delete();
            q64.delete();
        end else if (in_valid && rdy64) begin
            q32.push_back(ref_model(in_inst, 32, in_tag));
            q64.push_back(ref_model(in_inst, 64, in_tag));
        end
    end

    // Scoreboard output side: compare the presented head, retire it on a pop.
    exp_t e32, e64;
    always @(negedge clk) begin
        if (ov64) begin
            if (q64.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb64_unexpected: got tag 0x%0h expected no output", tag64);
            end else begin
                e64 = q64[0];
                chk("sb64_imm", imm64, e64.imm);
                chk("sb64_fmt", 64'(fmt64), 64'(e64.fmt));
                chk("sb64_ill", 64'(ill64), 64'(e64.ill));
                chk("sb64_tag", 64'(tag64), 64'(e64.tag));
                if (out_ready) void'(q64.pop_front());
            end
        end
        if (ov32) begin
            if (q32.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb32_unexpected: got tag 0x%0h expected no output", tag32);
            end else begin
                e32 = q32[0];
                chk("sb32_imm", 64'(imm32), e32.imm);
                chk("sb32_fmt", 64'(fmt32), 64'(e32.fmt));
                chk("sb32_ill", 64'(ill32), 64'(e32.ill));
                chk("sb32_tag", 64'(tag32), 64'(e32.tag));
                if (out_ready) void'(q32.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_check(input string name, input logic [31:0] inst, input logic [31:0] tag,
                              input logic [63:0] e64, input logic [31:0] e32,
                              input logic [2:0] efmt, input logic eill);
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = inst;
        in_tag    = tag;
        chk({name, "_in_ready"}, 64'(rdy64), 64'd1);
        tick();
        in_valid = 1'b0;
        chk({name, "_valid"}, 64'(ov64), 64'd1);
        chk({name, "_imm64"}, imm64, e64);
        chk({name, "_imm32"}, 64'(imm32), 64'(e32));
        chk({name, "_fmt"}, 64'(fmt64), 64'(efmt));
        chk({name, "_ill"}, 64'(ill32), 64'(eill));
        chk({name, "_tag"}, 64'(tag32), 64'(tag));
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(rdy64), 64'd0);
        chk("rst_out_valid", 64'(ov32), 64'd0);
        chk("rst_out_imm", imm64, 64'd0);
        chk("rst_out_fmt", 64'(fmt64), 64'd0);
        chk("rst_out_tag", 64'(tag64), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(rdy32), 64'd1);

        // Directed decodes
        send_check("addi",  32'hFFF00093, 32'h100, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 1'b0);
        send_check("sw",    32'hFE112E23, 32'h104, 64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd1, 1'b0);
        send_check("lui_n", 32'h800000B7, 32'h108, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 3'd3, 1'b0);
        send_check("lui_p", 32'h123450B7, 32'h10C, 64'h0000_0000_1234_5000, 32'h1234_5000, 3'd3, 1'b0);
        send_check("csrwi", 32'h300FD073, 32'h110, 64'h1F, 32'h1F, 3'd5, 1'b0);
        send_check("zero",  32'h00000000, 32'h114, 64'h0, 32'h0, 3'd6, 1'b1);

        // Backpressure: A and B fill the buffer, C waits, then all drain in order
        tick();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = rand_inst(); in_tag = 32'hA;
        tick();
        in_inst = rand_inst(); in_tag = 32'hB;
        chk("bp_head_a", 64'(tag64), 64'hA);
        tick();
        in_inst = rand_inst(); in_tag = 32'hC;
        chk("bp_full_ready", 64'(rdy64), 64'd0);
        tick();
        chk("bp_hold_ready", 64'(rdy32), 64'd0);
        chk("bp_hold_head", 64'(tag32), 64'hA);
        out_ready = 1'b1;
        tick();
        chk("bp_head_b", 64'(tag64), 64'hB);
        chk("bp_ready_back", 64'(rdy64), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_head_c", 64'(tag64), 64'hC);
        tick();
        chk("bp_empty", 64'(ov64), 64'd0);

        // Flush at count 2 with in_valid held, then at count 1 with a real handshake
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = rand_inst(); in_tag = 32'hF0;
        tick();
        in_inst = rand_inst(); in_tag = 32'hF1;
        tick();
        in_inst = rand_inst(); in_tag = 32'hF2;
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl2_valid", 64'(ov64), 64'd0);
        chk("fl2_ready", 64'(rdy64), 64'd1);
        in_valid = 1'b1; in_inst = rand_inst(); in_tag = 32'hF3;
        tick();
        in_inst = rand_inst(); in_tag = 32'hF4;
        flush = 1'b1;
        chk("fl1_ready", 64'(rdy32), 64'd1);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("fl1_valid", 64'(ov32), 64'd0);
        tick();
        chk("fl1_no_ghost", 64'(ov64), 64'd0);

        // Reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = rand_inst(); in_tag = 32'hE0;
        tick();
        in_inst = rand_inst(); in_tag = 32'hE1;
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_in_ready", 64'(rdy64), 64'd0);
        tick();
        chk("mrst_valid", 64'(ov64), 64'd0);
        chk("mrst_imm", imm64, 64'd0);
        chk("mrst_tag", 64'(tag32), 64'd0);
        chk("mrst_ill", 64'(ill32), 64'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mrst_ready_after", 64'(rdy64), 64'd1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            tick();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            in_tag    = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            rst       = ($urandom_range(0, 255) == 0);
        end
        tick();
        in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        chk("drain_q64", 64'(q64.size()), 64'd0);
        chk("drain_q32", 64'(q32.size()), 64'd0);
        chk("drain_valid", 64'(ov64), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
